optimized_mux: RTL and testbench

//  4:1 single-bit multiplexer, built twice for LUT-mapping comparison:
//  - a direct sum-of-products form
//  - an optimized 2-level mux-tree form that maps to one LUT6 (4 data + 2 select)

---
 rtl/optimized_mux.sv | 60 ++++++
 tb/tb_optimized_mux.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/optimized_mux.sv
// 4:1 single-bit mux in two equivalent forms (sum-of-products and 2-level tree),
// with a registered select result and a sticky/counting cross-check between the forms.
module optimized_mux #(
    parameter int CNT_W   = 8,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D,
    input  logic [1:0]       S,
    output logic             y_dr,
    output logic             y_op,
    output logic             y_q,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic diff;

    assign y_dr = (~S[1] & ~S[0] & D[0]) |
                  (~S[1] &  S[0] & D[1]) |
                  ( S[1] & ~S[0] & D[2]) |
                  ( S[1] &  S[0] & D[3]);

    // Tree form: S[0] picks within each pair, S[1] picks the pair.
    assign y_op = S[1] ? (S[0] ? D[3] : D[2]) : (S[0] ? D[1] : D[0]);

    assign diff = y_dr ^ y_op;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else if (diff) begin
            mismatch <= 1'b1;
            if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_q <= 1'b0;
                end else begin
                    y_q <= y_op;
                end
            end
        end else begin : g_comb_out
            assign y_q = y_op;
        end
    endgenerate

endmodule

// File: tb/tb_optimized_mux.sv
// Directed self-checking bench for optimized_mux: registered and combinational
// y_q variants, exhaustive equivalence sweep, forced mismatch saturation, reset.
module tb_optimized_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D;
    logic [1:0] S;

    logic       y_dr, y_op, y_q, mismatch;
    logic [7:0] err_cnt;
    logic       c_y_dr, c_y_op, c_y_q, c_mismatch;
    logic [7:0] c_err_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    optimized_mux #(.CNT_W(8), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .D(D), .S(S),
        .y_dr(y_dr), .y_op(y_op), .y_q(y_q),
        .mismatch(mismatch), .err_cnt(err_cnt)
    );

    optimized_mux #(.CNT_W(8), .REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .D(D), .S(S),
        .y_dr(c_y_dr), .y_op(c_y_op), .y_q(c_y_q),
        .mismatch(c_mismatch), .err_cnt(c_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after a rising edge; sample 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] d_v;
        logic       exp_bit;
        logic       prev_bit;

        rst = 1'b1;
        D   = 4'b0000;
        S   = 2'b00;
        #2;
        check("reset y_q", 32'(y_q), 32'd0);
        check("reset mismatch", 32'(mismatch), 32'd0);
        check("reset err_cnt", 32'(err_cnt), 32'd0);
        tick();
        check("reset holds y_q over edge", 32'(y_q), 32'd0);
        rst = 1'b0;

        // D=0110 stepped through S: expected 0,1,1,0 with y_q one cycle behind.
        D = 4'b0110;
        prev_bit = 1'b0;
        for (int s = 0; s < 4; s++) begin
            S = 2'(s);
            exp_bit = (s == 1 || s == 2);
            #1;
            check($sformatf("pat0110 y_dr s=%0d", s), 32'(y_dr), 32'(exp_bit));
            check($sformatf("pat0110 y_op s=%0d", s), 32'(y_op), 32'(exp_bit));
            tick();
            check($sformatf("pat0110 y_q s=%0d", s), 32'(y_q), 32'(exp_bit));
            prev_bit = exp_bit;
        end

        // Exhaustive sweep: expected bit is D shifted right by S.
        for (int d = 0; d < 16; d++) begin
            for (int s = 0; s < 4; s++) begin
                D = 4'(d);
                S = 2'(s);
                d_v = 4'(d) >> s;
                exp_bit = d_v[0];
                #1;
                check($sformatf("sweep y_dr d=%0h s=%0d", d, s), 32'(y_dr), 32'(exp_bit));
                check($sformatf("sweep y_op d=%0h s=%0d", d, s), 32'(y_op), 32'(exp_bit));
                tick();
                check($sformatf("sweep y_q d=%0h s=%0d", d, s), 32'(y_q), 32'(exp_bit));
            end
        end
        check("sweep mismatch", 32'(mismatch), 32'd0);
        check("sweep err_cnt", 32'(err_cnt), 32'd0);

        // Walking one on D against every select value.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                D = 4'(1 << i);
                S = 2'(j);
                #1;
                check($sformatf("walk y_op bit=%0d s=%0d", i, j), 32'(y_op), 32'(i == j));
                check($sformatf("walk y_dr bit=%0d s=%0d", i, j), 32'(y_dr), 32'(i == j));
                tick();
            end
        end

        // Combinational y_q variant, no clock edge between input change and check.
        D = 4'b1010;
        S = 2'b11;
        #1;
        check("comb y_q D=1010 S=11", 32'(c_y_q), 32'd1);
        S = 2'b00;
        #1;
        check("comb y_q D=1010 S=00", 32'(c_y_q), 32'd0);
        tick();

        // Force the tree output high while the SOP form is low.
        D = 4'b0000;
        S = 2'b00;
        force dut.y_op = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("forced err_cnt after 10", 32'(err_cnt), 32'd10);
        check("forced mismatch after 10", 32'(mismatch), 32'd1);
        for (int k = 10; k < 300; k++) tick();
        check("forced err_cnt saturated", 32'(err_cnt), 32'd255);
        check("forced mismatch", 32'(mismatch), 32'd1);
        check("unforced instance err_cnt", 32'(c_err_cnt), 32'd0);
        release dut.y_op;
        #1;
        tick();
        tick();
        check("sticky mismatch after release", 32'(mismatch), 32'd1);
        check("err_cnt holds after release", 32'(err_cnt), 32'd255);

        // Asynchronous reset mid-cycle while y_q is 1.
        D = 4'b1000;
        S = 2'b11;
        tick();
        check("pre-reset y_q", 32'(y_q), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async reset y_q", 32'(y_q), 32'd0);
        check("async reset mismatch", 32'(mismatch), 32'd0);
        check("async reset err_cnt", 32'(err_cnt), 32'd0);
        tick();
        check("reset wins over edge y_q", 32'(y_q), 32'd0);
        rst = 1'b0;
        tick();
        check("capture resumes y_q", 32'(y_q), 32'd1);
        check("post-reset mismatch", 32'(mismatch), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
